// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, default widths and sizing helper for the bus interconnect
package bus_pkg;
  localparam int NSLV_DEF = 6;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;
  localparam int ERRCNT_W = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: combinational base/mask decode; lowest-index hit wins
//   addr_i   in  AW         address to decode
//   hit_o    out 1          some slave matches
//   onehot_o out NSLV       one-hot winning slave
//   idx_o    out idx_w(NSLV) index of winning slave
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int NSLV = NSLV_DEF,
  parameter int AW = AW_DEF,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0
) (
  input  logic [AW-1:0]          addr_i,
  output logic                   hit_o,
  output logic [NSLV-1:0]        onehot_o,
  output logic [idx_w(NSLV)-1:0] idx_o
);
  localparam int IW = idx_w(NSLV);
  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit_o = 1'b0;
    onehot_o = '0;
    idx_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit_o = 1'b1;
        onehot_o = '0;
        onehot_o[i] = 1'b1;
        idx_o = IW'(i);
      end
    end
  end
endmodule

// File: rtl/bus_interconnect.sv
// bus_interconnect: single master to NSLV slaves with decode, wait-state timeout and error counting
//   clk, rst                 clock, async active-high reset
//   bReq/bAddr/bWData/bWrite master request (sampled only in IDLE)
//   bReady/bRData/bErr       one-cycle completion, data and error
//   bErrCnt                  saturating error-response count
//   bSel                     one-hot slave select during ACCESS
//   sAddr/sWData/sWrite      latched request broadcast to all slaves
//   sRData/sReady            packed slave read data and completions
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int NSLV = NSLV_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bReq,
  input  logic [AW-1:0]       bAddr,
  input  logic [DW-1:0]       bWData,
  input  logic                bWrite,
  output logic                bReady,
  output logic [DW-1:0]       bRData,
  output logic                bErr,
  output logic [ERRCNT_W-1:0] bErrCnt,
  output logic [NSLV-1:0]     bSel,
  output logic [AW-1:0]       sAddr,
  output logic [DW-1:0]       sWData,
  output logic                sWrite,
  input  logic [NSLV*DW-1:0]  sRData,
  input  logic [NSLV-1:0]     sReady
);
  localparam int IW = idx_w(NSLV);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic write_q, write_d, err_q, err_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic dec_hit;
  logic [NSLV-1:0] dec_onehot;
  logic [IW-1:0] dec_idx;
  bus_addr_decoder #(
    .NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_dec (
    .addr_i(bAddr), .hit_o(dec_hit), .onehot_o(dec_onehot), .idx_o(dec_idx)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    sel_d = sel_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bReq) begin
        state_d = dec_hit ? ACCESS : ERR;
        if (dec_hit) begin
          addr_d = bAddr;
          wdata_d = bWData;
          write_d = bWrite;
          sel_d = dec_onehot;
          idx_d = dec_idx;
          cnt_d = '0;
        end
      end
      // Masking with sel_q ignores completions from every other slave.
      ACCESS: if (|(sReady & sel_q)) begin
        state_d = RESP;
        rdata_d = write_q ? '0 : sRData[idx_q*DW +: DW];
        err_d = 1'b0;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = RESP;
        rdata_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bReady = state_q == RESP || state_q == ERR;
  assign bErr = state_q == ERR || (state_q == RESP && err_q);
  assign bRData = state_q == RESP ? rdata_q : '0;
  assign bSel = state_q == ACCESS ? sel_q : '0;
  assign bErrCnt = errcnt_q;
  assign sAddr = addr_q;
  assign sWData = wdata_q;
  assign sWrite = write_q;
  assign errcnt_d = (bReady && bErr && errcnt_q != '1) ? errcnt_q + 1'b1 : errcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      sel_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      sel_q <= sel_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      errcnt_q <= errcnt_d;
    end
  end
endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: randomized transactions checked against a transaction-level reference model
module tb_bus_interconnect;
  localparam int N = 6;
  localparam int TMO = 15;
  localparam logic [N*32-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h2000_0000,
                                      32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                      32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000};
  logic clk = 1'b0, rst, bReq, bWrite, bReady, bErr, sWrite;
  logic [31:0] bAddr, bWData, bRData, sAddr, sWData;
  logic [7:0] bErrCnt;
  logic [N-1:0] bSel, sReady;
  logic [N*32-1:0] sRData;
  int total = 0, bad = 0, errcnt_m = 0;
  logic [31:0] la_m = '0, lw_m = '0;
  logic lwr_m = 1'b0;
  bus_interconnect #(
    .NSLV(N), .DW(32), .AW(32), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bReq(bReq), .bAddr(bAddr), .bWData(bWData), .bWrite(bWrite),
    .bReady(bReady), .bRData(bRData), .bErr(bErr), .bErrCnt(bErrCnt), .bSel(bSel),
    .sAddr(sAddr), .sWData(sWData), .sWrite(sWrite), .sRData(sRData), .sReady(sReady)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
    return -1;
  endfunction
  // Called #1 after a rising edge with the DUT in IDLE; w = wait cycles before the slave answers.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input int w, input logic [31:0] rd);
    int idx, kr;
    logic exp_e;
    logic [31:0] exp_d;
    idx = decode(a);
    exp_e = idx < 0 || w >= TMO;
    kr = idx < 0 ? 0 : (w < TMO ? w : TMO - 1) + 1;
    exp_d = (exp_e || wr) ? 32'h0 : rd;
    for (int i = 0; i < N; i++) sRData[i*32 +: 32] = $urandom;
    if (idx >= 0) sRData[idx*32 +: 32] = rd;
    bReq = 1'b1; bAddr = a; bWData = wd; bWrite = wr; sReady = '0;
    @(posedge clk); #1;
    bReq = 1'($urandom_range(0, 1)); bAddr = $urandom; bWData = $urandom;
    bWrite = 1'($urandom_range(0, 1));
    for (int k = 0; k <= kr; k++) begin
      sReady = N'($urandom);
      if (idx >= 0 && k < kr) sReady[idx] = (k == w);
      chk("bsel", 32'(bSel), (idx >= 0 && k < kr) ? 32'(1) << idx : 32'h0);
      chk("ready", 32'(bReady), 32'(k == kr));
      chk("rdata", bRData, k == kr ? exp_d : 32'h0);
      chk("err", 32'(bErr), 32'(k == kr && exp_e));
      if (k == kr) bReq = 1'b0;
      @(posedge clk); #1;
    end
    if (exp_e && errcnt_m < 255) errcnt_m++;
    if (idx >= 0) begin la_m = a; lw_m = wd; lwr_m = wr; end
    chk("errcnt", 32'(bErrCnt), 32'(errcnt_m));
    chk("saddr", sAddr, la_m);
    chk("swdata", sWData, lw_m);
    chk("swrite", 32'(sWrite), 32'(lwr_m));
    chk("idle_ready", 32'(bReady), 32'h0);
  endtask
  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return {16'h0000, r[15:0]};
      1: return {20'h00010, r[11:0]};
      2: return {16'h0001, r[15:0]};
      3: return {3'b001, r[28:0]};
      default: return r;
    endcase
  endfunction
  initial begin
    rst = 1'b1; bReq = 1'b0; bAddr = '0; bWData = '0; bWrite = 1'b0; sReady = '0; sRData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bsel", 32'(bSel), 32'h0);
    chk("rst_ready", 32'(bReady), 32'h0);
    chk("rst_err", 32'(bErr), 32'h0);
    chk("rst_rdata", bRData, 32'h0);
    chk("rst_errcnt", 32'(bErrCnt), 32'h0);
    chk("rst_saddr", sAddr, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_txn(32'h0000_0010, 32'h0, 1'b0, 0, 32'hDEAD_BEEF);
    do_txn(32'h0001_0004, 32'h5A, 1'b1, 3, $urandom);
    do_txn(32'h8000_0000, 32'h0, 1'b0, 0, $urandom);
    do_txn(32'h0001_0008, 32'h0, 1'b0, 1000, $urandom);
    do_txn(32'h0001_1000, 32'h0, 1'b0, 0, 32'h2222_2222);
    do_txn(32'h2000_0000, 32'h0, 1'b0, TMO - 1, 32'h3333_3333);
    for (int t = 0; t < 200; t++)
      do_txn(rand_addr(), $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0 ? 20 : $urandom_range(0, 5), $urandom);
    bReq = 1'b1; bAddr = 32'h0001_0004; bWrite = 1'b0; sReady = '0;
    @(posedge clk); #1;
    bReq = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_bsel", 32'(bSel), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_bsel", 32'(bSel), 32'h0);
    chk("mid_rst_ready", 32'(bReady), 32'h0);
    chk("mid_rst_errcnt", 32'(bErrCnt), 32'h0);
    chk("mid_rst_saddr", sAddr, 32'h0);
    @(posedge clk); #1;
    chk("hold_rst_ready", 32'(bReady), 32'h0);
    errcnt_m = 0; la_m = '0; lw_m = '0; lwr_m = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_txn(32'h0000_0010, 32'h0, 1'b0, 0, 32'h1234_5678);
    for (int t = 0; t < 260; t++)
      do_txn(32'h8000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF)), $urandom, 1'b0, 0, $urandom);
    chk("errcnt_sat", 32'(bErrCnt), 32'd255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 NSLV, 6, number of slave ports (1..16).
REQ-002 DW, 32, data width; AW, 32, address width.
REQ-003 SLV_BASE, {NSLV{32'h0}}, packed NSLV*AW base addresses, slave i in bits [i*AW +: AW].
REQ-004 SLV_MASK, {NSLV{32'h0}}, packed NSLV*AW decode masks, same packing.
REQ-005 TIMEOUT, 15, maximum ACCESS cycles before an error response (1..255).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 bReq  in  1  master request; bAddr, bWData and bWrite are valid while bReq=1.
REQ-009 bAddr  in  AW  master address.
REQ-010 bWData  in  DW  master write data.
REQ-011 bWrite  in  1  1=write, 0=read.
REQ-012 bReady  out  1  one-cycle completion pulse.
REQ-013 bRData  out  DW  read data, valid when bReady=1.
REQ-014 bErr  out  1  error flag, valid when bReady=1.
REQ-015 bErrCnt  out  8  saturating count of error responses.
REQ-016 bSel  out  NSLV  one-hot slave select, high only in ACCESS.
REQ-017 sAddr, sWData, sWrite  out  AW, DW, 1  latched request forwarded to all slaves.
REQ-018 sRData  in  NSLV*DW  packed slave read data.
REQ-019 sReady  in  NSLV  per-slave completion.

Function
REQ-020 Slave i hits when (bAddr & mask_i) == base_i; with several hits, the lowest index wins.
REQ-021 FSM states: IDLE, ACCESS, RESP, ERR.
REQ-022 IDLE with bReq=1 and a hit: latch bAddr, bWData, bWrite and the hit index; go to ACCESS; clear the timeout counter.
REQ-023 IDLE with bReq=1 and no hit: go to ERR; no bSel bit asserts.
REQ-024 ACCESS: bSel[idx]=1; only sReady[idx] is honoured; when it is 1, capture sRData[idx] (0 on writes) and go to RESP with error=0.
REQ-025 ACCESS without sReady[idx]: increment the counter; when it reaches TIMEOUT, go to RESP with error=1 and data=0, and deassert bSel.
REQ-026 RESP: bReady=1, bRData=captured data, bErr=error flag for exactly one cycle; then IDLE.
REQ-027 ERR: bReady=1, bErr=1, bRData=0 for one cycle; then IDLE.
REQ-028 bRData=0 and bErr=0 whenever bReady=0.
REQ-029 bErrCnt increments by 1 on every cycle with bReady=1 and bErr=1; it holds at 255.
REQ-030 Minimum latency (zero-wait slave): bReady asserts 2 cycles after bReq is sampled in IDLE; back-to-back throughput is one transaction per 3 cycles.
REQ-031 bReq is sampled only in IDLE; deasserting or changing it mid-transaction does not abort or alter the transaction.
REQ-032 sReady from non-selected slaves, and sReady in IDLE, RESP or ERR, is ignored.
REQ-033 sAddr, sWData and sWrite hold the latched values from the IDLE acceptance until the next acceptance.

Reset
REQ-034 rst=1 forces IDLE immediately and clears bSel, bReady, bErr, bRData, bErrCnt, the timeout counter, the latched request and the captured data to 0.
REQ-035 rst=1 mid-ACCESS drops the transaction without a bReady pulse; operation resumes on the first rising clk edge after rst=0.

Structure
REQ-036 Package bus_pkg holds the state enum, default DW/AW/NSLV, and the error-count width.
REQ-037 Sub-module bus_addr_decoder (parametrised NSLV/AW/SLV_BASE/SLV_MASK): combinational hit flag, one-hot vector and index; the FSM, counters and data capture live in bus_interconnect.

Verification
REQ-038 Map: slave0 base 0x00000000 mask 0xFFFF0000; slave1 base 0x00010000 mask 0xFFFFF000. Read 0x00000010, sRData0=0xDEADBEEF, sReady0 returns on first ACCESS cycle -> bSel=000001 for 1 cycle; bReady=1 and bRData=0xDEADBEEF, bErr=0, 2 cycles after request.
REQ-039 Write 0x00010004 data 0x5A, sReady1 after 3 wait cycles -> sWData=0x5A, sWrite=1; bSel=000010 for 4 cycles; bReady 5 cycles after request; bErr=0.
REQ-040 Read 0x80000000 (unmapped) -> bSel stays 0; next cycle bReady=1, bErr=1, bRData=0; bErrCnt goes 0->1.
REQ-041 Read slave1 with sReady1 never asserted and sReady0 pulsed -> bSel1 high for TIMEOUT=15 cycles, then bReady=1, bErr=1, bRData=0; sReady0 has no effect.
REQ-042 Assert rst during the 2nd ACCESS cycle -> bSel=0 immediately and no bReady; a subsequent read of 0x00000010 completes normally. Separately, issue 260 unmapped reads -> bErrCnt=255.
